// File: rtl/mux4a1_arbiter_if.sv
// Channel-side and output-side bus of the 4:1 burst arbiter.
//   req        : per-channel word-available flags (bit i = channel i)
//   data_in0..3: channel words
//   out_ready  : downstream accepts data_out this cycle
//   pop        : one-hot consume strobe for the granted channel
//   sel        : current grant index
//   data_out   : registered selected word
//   valid_out  : data_out holds a word not yet accepted
//   busy       : arbiter is in a grant
interface mux4a1_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [3:0]            req;
  logic [DATA_WIDTH-1:0] data_in0;
  logic [DATA_WIDTH-1:0] data_in1;
  logic [DATA_WIDTH-1:0] data_in2;
  logic [DATA_WIDTH-1:0] data_in3;
  logic                  out_ready;
  logic [3:0]            pop;
  logic [1:0]            sel;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;
  logic                  busy;

  // Requester / downstream side
  modport master (
    output req, data_in0, data_in1, data_in2, data_in3, out_ready,
    input  pop, sel, data_out, valid_out, busy
  );

  // Arbiter side
  modport slave (
    input  req, data_in0, data_in1, data_in2, data_in3, out_ready,
    output pop, sel, data_out, valid_out, busy
  );
endinterface

// File: rtl/mux4a1_arbiter.sv
// Round-robin 4:1 burst arbiter with a registered output stage.
// Grants one channel for up to MAX_BURST words, then rotates.
//   clk     : clock, rising edge
//   reset_L : asynchronous active-low reset
//   bus     : mux4a1_arbiter_if.slave (req/data_in*/out_ready in,
//             pop/sel/data_out/valid_out/busy out)
// pop is combinational (consume strobe in the same cycle); the rest is
// registered or decoded directly from flops.
module mux4a1_arbiter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic             clk,
  input  logic             reset_L,
  mux4a1_arbiter_if.slave  bus
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [1:0]            g_q, g_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;

  logic                  can_accept;
  logic                  xfer;
  logic                  eob;
  logic                  any_req;
  logic [1:0]            rr_next;
  logic [DATA_WIDTH-1:0] mux_word;

  // Round-robin search: g+1 has highest priority, g itself lowest.
  function automatic logic [1:0] rr_pick(input logic [1:0] g, input logic [3:0] r);
    logic [1:0] pick;
    logic [1:0] idx;
    pick = g;
    for (int k = 4; k >= 1; k--) begin
      idx = g + 2'(k);
      if (r[idx]) pick = idx;
    end
    return pick;
  endfunction

  // 4:1 data mux driven by the grant index
  always_comb begin
    mux_word = bus.data_in0;
    case (g_q)
      2'd0:    mux_word = bus.data_in0;
      2'd1:    mux_word = bus.data_in1;
      2'd2:    mux_word = bus.data_in2;
      default: mux_word = bus.data_in3;
    endcase
  end

  assign any_req    = |bus.req;
  assign rr_next    = rr_pick(g_q, bus.req);
  assign can_accept = !valid_q || bus.out_ready;
  assign xfer       = (state_q == GRANT) && bus.req[g_q] && can_accept;
  // Burst ends on the last allowed word or when the granted channel runs dry.
  assign eob        = (xfer && (cnt_q == CNT_W'(MAX_BURST - 1))) || !bus.req[g_q];

  // Next-state, grant and output-stage logic
  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = valid_q;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = GRANT;
          g_d     = rr_next;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (xfer) cnt_d = cnt_q + CNT_W'(1);
        if (eob) begin
          if (any_req) begin
            // Re-picks g itself when it is the only requester.
            g_d   = rr_next;
            cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (xfer) begin
      data_d  = mux_word;
      valid_d = 1'b1;
    end else if (bus.out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= IDLE;
      g_q     <= 2'd3;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign bus.pop       = xfer ? 4'(4'b0001 << g_q) : 4'b0000;
  assign bus.sel       = g_q;
  assign bus.data_out  = data_q;
  assign bus.valid_out = valid_q;
  assign bus.busy      = (state_q == GRANT);

endmodule

// File: tb/tb_mux4a1_arbiter.sv
// Randomised bench for mux4a1_arbiter against a behavioural burst model.
module tb_mux4a1_arbiter;

  localparam int unsigned DW = 8;
  localparam int unsigned MB = 4;

  logic clk;
  logic reset_L;
  int   n_vec;
  int   n_err;

  mux4a1_arbiter_if #(.DATA_WIDTH(DW)) bus ();

  mux4a1_arbiter #(.DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: which channel owns the bus, words moved so far, output reg.
  bit          m_busy;
  int          m_ch;
  int          m_words;
  bit          m_valid;
  logic [7:0]  m_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int next_owner(input int from, input logic [3:0] r);
    for (int k = 1; k <= 4; k++) begin
      if (r[(from + k) % 4]) return (from + k) % 4;
    end
    return from;
  endfunction

  task automatic model_reset();
    m_busy  = 0;
    m_ch    = 3;
    m_words = 0;
    m_valid = 0;
    m_data  = '0;
  endtask

  // One clock: drive inputs, compare everything, then advance the model across the edge.
  task automatic step(input logic [3:0] r, input logic rdy, input logic [31:0] w);
    bit         moving;
    bit         done;
    logic [3:0] exp_pop;
    logic [7:0] words [4];
    @(negedge clk);
    bus.req       = r;
    bus.out_ready = rdy;
    bus.data_in0  = w[7:0];
    bus.data_in1  = w[15:8];
    bus.data_in2  = w[23:16];
    bus.data_in3  = w[31:24];
    words[0] = w[7:0];
    words[1] = w[15:8];
    words[2] = w[23:16];
    words[3] = w[31:24];
    #1;
    moving  = m_busy && r[m_ch] && (!m_valid || rdy);
    exp_pop = moving ? 4'(1 << m_ch) : 4'b0000;
    chk("pop",   32'(bus.pop),       32'(exp_pop));
    chk("sel",   32'(bus.sel),       32'(m_ch));
    chk("busy",  32'(bus.busy),      32'(m_busy));
    chk("valid", 32'(bus.valid_out), 32'(m_valid));
    chk("data",  32'(bus.data_out),  32'(m_data));

    if (moving) begin
      m_data  = words[m_ch];
      m_valid = 1;
    end else if (rdy) begin
      m_valid = 0;
    end
    if (!m_busy) begin
      if (r != 0) begin
        m_ch    = next_owner(m_ch, r);
        m_words = 0;
        m_busy  = 1;
      end
    end else begin
      if (moving) m_words++;
      done = (moving && m_words == MB) || !r[m_ch];
      if (done) begin
        if (r != 0) begin
          m_ch    = next_owner(m_ch, r);
          m_words = 0;
        end else begin
          m_busy = 0;
        end
      end
    end
  endtask

  // Reset asserted between edges; outputs must drop with no clock edge.
  task automatic async_reset();
    @(posedge clk);
    #2;
    reset_L = 1'b0;
    #1;
    chk("rst_pop",   32'(bus.pop),       32'h0);
    chk("rst_busy",  32'(bus.busy),      32'h0);
    chk("rst_valid", 32'(bus.valid_out), 32'h0);
    chk("rst_sel",   32'(bus.sel),       32'h3);
    chk("rst_data",  32'(bus.data_out),  32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    reset_L = 1'b1;
  endtask

  logic [3:0] r;
  logic       rdy;

  initial begin
    n_vec = 0;
    n_err = 0;
    reset_L       = 1'b0;
    bus.req       = '0;
    bus.out_ready = 1'b0;
    bus.data_in0  = '0;
    bus.data_in1  = '0;
    bus.data_in2  = '0;
    bus.data_in3  = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    reset_L = 1'b1;

    // Single request on channel 0: grant, pop, then registered word.
    step(4'b0001, 1'b1, {$urandom() & 32'hFFFFFF00} | 32'hA5);
    step(4'b0001, 1'b1, {$urandom() & 32'hFFFFFF00} | 32'hA5);
    chk("first_pop",  32'(bus.pop),  32'h1);
    chk("first_sel",  32'(bus.sel),  32'h0);
    chk("first_busy", 32'(bus.busy), 32'h1);
    step(4'b0000, 1'b1, $urandom());
    chk("first_data",  32'(bus.data_out),  32'hA5);
    chk("first_valid", 32'(bus.valid_out), 32'h1);

    // All channels requesting with a free downstream: back-to-back bursts.
    for (int i = 0; i < 40; i++) step(4'b1111, 1'b1, $urandom());
    async_reset();
    // Only channel 1 requesting: re-grant after each full burst.
    for (int i = 0; i < 20; i++) step(4'b0010, 1'b1, $urandom());
    // All channels, downstream stalling at random.
    for (int i = 0; i < 40; i++) step(4'b1111, 1'($urandom_range(1)), $urandom());

    // Sticky random requests with random backpressure.
    r = 4'($urandom());
    for (int i = 0; i < 600; i++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(7) == 0) r[b] = ~r[b];
      end
      rdy = ($urandom_range(3) != 0);
      step(r, rdy, $urandom());
      if (i == 300) async_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
